// File: rtl/demux64_1x2.sv
// demux64_1x2: valid/ready 1-to-2 demultiplexer with one holding slot per destination.
// Define DEMUX64_XFER_COUNT_EN to add the 16-bit output transfer counters CNT0/CNT1.
module demux64_1x2 #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
  input  logic             S,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic             Y0_VALID,
  output logic             Y1_VALID,
  input  logic             Y0_READY,
  input  logic             Y1_READY
`ifdef DEMUX64_XFER_COUNT_EN
  ,
  output logic [15:0]      CNT0,
  output logic [15:0]      CNT1
`endif
);
  logic drain0, drain1, load0, load1;
  assign drain0 = Y0_VALID && Y0_READY;
  assign drain1 = Y1_VALID && Y1_READY;
  // Only the selected slot gates I_READY, so a stalled slot never lets data bypass it.
  assign I_READY = RST && (S ? (!Y1_VALID || Y1_READY) : (!Y0_VALID || Y0_READY));
  assign load0 = I_VALID && I_READY && !S;
  assign load1 = I_VALID && I_READY && S;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Y0       <= '0;
      Y1       <= '0;
      Y0_VALID <= 1'b0;
      Y1_VALID <= 1'b0;
    end else begin
      if (load0) Y0 <= I;
      if (load1) Y1 <= I;
      Y0_VALID <= load0 ? 1'b1 : drain0 ? 1'b0 : Y0_VALID;
      Y1_VALID <= load1 ? 1'b1 : drain1 ? 1'b0 : Y1_VALID;
    end
  end
`ifdef DEMUX64_XFER_COUNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CNT0 <= '0;
      CNT1 <= '0;
    end else begin
      if (drain0) CNT0 <= CNT0 + 16'd1;
      if (drain1) CNT1 <= CNT1 + 16'd1;
    end
  end
`endif
endmodule

// File: doc/demux64_1x2.md
DEMUX64_1X2 -- requirements
Module: demux64_1x2

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, data width of I, Y0 and Y1.
REQ-002 The block SHALL have port CLK, input, 1, rising-edge clock.
REQ-003 The block SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port I, input, WIDTH, data word offered by the producer.
REQ-005 The block SHALL have port S, input, 1, destination select (0 -> Y0, 1 -> Y1), sampled with I.
REQ-006 The block SHALL have port I_VALID, input, 1, producer asserts that I and S are valid.
REQ-007 The block SHALL have port I_READY, output, 1, block can accept I this cycle.
REQ-008 The block SHALL have ports Y0 and Y1, output, WIDTH, held data for destination 0 and destination 1.
REQ-009 The block SHALL have ports Y0_VALID and Y1_VALID, output, 1, the corresponding Y holds an undelivered word.
REQ-010 The block SHALL have ports Y0_READY and Y1_READY, input, 1, the consumer accepts the corresponding Y this cycle.

Function
REQ-011 The block SHALL keep one holding slot per destination, with states EMPTY (Yn_VALID=0) and FULL (Yn_VALID=1).
REQ-012 An input transfer SHALL occur on a rising CLK edge when I_VALID=1 and I_READY=1.
REQ-013 An output transfer on destination n SHALL occur on a rising CLK edge when Yn_VALID=1 and Yn_READY=1.
REQ-014 I_READY SHALL be combinational: 1 when the slot selected by S is EMPTY, or FULL with its Yn_READY=1 in the same cycle; otherwise 0.
REQ-015 I_READY SHALL not depend on I_VALID.
REQ-016 On an input transfer, I SHALL be loaded into slot S and Yn_VALID SHALL be 1 from the next cycle (latency 1 cycle, no combinational I-to-Y path).
REQ-017 The non-selected slot SHALL be unaffected by an input transfer.
REQ-018 Slot transitions on each edge SHALL be:
  - EMPTY -> FULL on a load.
  - FULL -> EMPTY on a drain without a load.
  - FULL -> FULL with new data on a simultaneous drain and load.
  - Otherwise the slot SHALL hold.
REQ-019 Yn SHALL hold its last value when EMPTY and SHALL change only on a load.
REQ-020 Both slots SHALL be able to drain in the same cycle, independently.
REQ-021 With slot S FULL and Yn_READY=0, I_READY SHALL be 0 and I SHALL not be consumed, even if the other slot is EMPTY (no reordering, no bypass).
REQ-022 S changing while I_VALID=1 and I_READY=0 SHALL re-evaluate I_READY against the new slot in the same cycle.

Reset
REQ-023 While RST=0, the block SHALL immediately, without waiting for CLK, force Y0=0, Y1=0, Y0_VALID=0, Y1_VALID=0, and both slots to EMPTY.
REQ-024 While RST=0, I_READY SHALL be 0, and no transfer SHALL occur.
REQ-025 Reset asserted mid-transfer SHALL discard held words without delivering them.
REQ-026 After RST deasserts, the first input transfer SHALL be possible at the first rising edge.

Configuration
REQ-027 The block SHALL use macro DEMUX64_XFER_COUNT_EN to compile transfer counters in or out.
REQ-028 When DEMUX64_XFER_COUNT_EN is defined, the block SHALL add output ports CNT0 and CNT1, 16 bits each, counting output transfers on Y0 and Y1.
REQ-029 CNT0 and CNT1 SHALL increment on output transfers only, SHALL wrap 16'hFFFF -> 0, and SHALL be cleared to 0 by RST.
REQ-030 When DEMUX64_XFER_COUNT_EN is undefined, CNT0 and CNT1 SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL cover reset: RST=0 with I_VALID=1, I=5 -> Y0=Y1=0, Y0_VALID=Y1_VALID=0, I_READY=0; release RST -> I_READY=1.
REQ-032 The bench SHALL cover routing: I=1431655700, S=0, one transfer -> next cycle Y0=1431655700, Y0_VALID=1, Y1_VALID=0; then I=1431655701, S=1 -> Y1=1431655701, Y1_VALID=1, Y0 unchanged.
REQ-033 The bench SHALL cover backpressure: Y0 FULL, Y0_READY=0, S=0, I_VALID=1 -> I_READY=0 for 10 cycles and Y0 unchanged; Y0_READY=1 -> I_READY=1, and new data appears next cycle with Y0_VALID still 1.
REQ-034 The bench SHALL cover simultaneous events: both slots FULL, Y0_READY=Y1_READY=1, new input S=1 same cycle -> Y0_VALID=0, Y1_VALID=1 with new data.
REQ-035 The bench SHALL cover mid-operation reset: RST pulsed low between edges with both slots FULL -> Y0_VALID and Y1_VALID drop within the same cycle, before the next edge.
REQ-036 The bench SHALL cover counter wrap, with DEMUX64_XFER_COUNT_EN defined: 65537 drains on Y1 -> CNT1=1, CNT0=0.
